// File: rtl/risc_core_param.sv
// risc_core_param: multicycle Simple RISC Machine core with a DATA_W-wide datapath.
// Ports: clk, reset_n (async active-low), s (start), load (IR load enable),
//        in[15:0] (instruction), out[DATA_W-1:0] (result register C),
//        N/V/Z (CMP flags), w (FSM in WAIT), ill (illegal encoding seen).
module risc_core_param #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              ill
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WRITE, WRITE_IMM} state_t;
    state_t state;
    logic [15:0] ir;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] a, b, rd_data, sh_data, alu, diff, imm;
    logic signed [7:0] imm8;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic is_movi, is_movr, is_alu, is_cmp, is_mvn;
    assign opc = ir[15:13];
    assign op = ir[12:11];
    assign rn = ir[10:8];
    assign rd = ir[7:5];
    assign sh = ir[4:3];
    assign rm = ir[2:0];
    assign imm8 = ir[7:0];
    assign imm = DATA_W'(imm8);
    assign is_movi = opc == 3'b110 && op == 2'b10;
    assign is_movr = opc == 3'b110 && op == 2'b00;
    assign is_alu = opc == 3'b101;
    assign is_cmp = is_alu && op == 2'b01;
    assign is_mvn = is_alu && op == 2'b11;
    assign w = state == WAIT;
    // single read port: Rn while fetching A, Rm otherwise
    assign rd_data = rf[state == GET_A ? rn : rm];
    assign sh_data = sh == 2'b01 ? {rd_data[DATA_W-2:0], 1'b0}
                   : sh == 2'b10 ? {1'b0, rd_data[DATA_W-1:1]}
                   : sh == 2'b11 ? {rd_data[DATA_W-1], rd_data[DATA_W-1:1]}
                   : rd_data;
    assign diff = a - b;
    assign alu = is_movr ? b : op == 2'b00 ? a + b : op == 2'b10 ? a & b : ~b;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT;
            ir <= '0;
            out <= '0;
            N <= 1'b0;
            V <= 1'b0;
            Z <= 1'b0;
            ill <= 1'b0;
            a <= '0;
            b <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (load) ir <= in;
                    if (s) begin
                        state <= DECODE;
                        ill <= 1'b0;
                    end
                end
                DECODE: begin
                    state <= is_movi ? WRITE_IMM : (is_movr || is_mvn) ? GET_B : is_alu ? GET_A : WAIT;
                    ill <= !(is_movi || is_movr || is_alu);
                end
                GET_A: begin
                    a <= rd_data;
                    state <= GET_B;
                end
                GET_B: begin
                    b <= sh_data;
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_cmp) begin
                        N <= diff[DATA_W-1];
                        Z <= diff == '0;
                        V <= (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
                    end
                    state <= is_cmp ? WAIT : WRITE;
                end
                WRITE: begin
                    out <= alu;
                    rf[rd] <= alu;
                    state <= WAIT;
                end
                WRITE_IMM: begin
                    rf[rn] <= imm;
                    state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule
